// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared fetch-path constants, opcodes and fetch FSM encoding.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int              PC_BITS  = 8;
    localparam logic [7:0]      RESET_PC = 8'h00;
    localparam int              INSTR_W  = 32;

    // Control-transfer opcodes, also decoded by the target calculator.
    localparam logic [6:0]      OP_JAL    = 7'b1101111;
    localparam logic [6:0]      OP_JALR   = 7'b1100111;
    localparam logic [6:0]      OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_KILL = 3'd3,
        ST_TRAP = 3'd4
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
//  Module      : fetch_skid_buf
//  Description : One-entry {instr, pc} holding register with full flag.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_skid_buf #(
    parameter int PC_BITS = cpu_pkg::PC_BITS,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_load,
    input  logic               i_pop,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_BITS-1:0] i_pc,
    output logic               o_full,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_BITS-1:0] o_pc
);

    logic               r_full;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_BITS-1:0] r_pc;

    // Clear wins over load so a redirect can never leave a stale entry behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_clr) begin
            r_full  <= 1'b0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_pop) begin
            r_full  <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
//  Module      : pc_fetch_ctrl
//  Description : Fetch PC owner: single-outstanding imem fetch, redirect/flush,
//                misaligned-target trap, output register plus skid buffer.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_ctrl #(
    parameter int                 PC_BITS  = cpu_pkg::PC_BITS,
    parameter logic [PC_BITS-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int                 INSTR_W  = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               redir_valid_i,
    input  logic [PC_BITS-1:0] redir_pc_i,
    output logic               imem_req_o,
    output logic [PC_BITS-1:0] imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_BITS-1:0] instr_pc_o,
    output logic               flush_o,
    output logic               trap_o,
    output logic [PC_BITS-1:0] trap_pc_o
);

    import cpu_pkg::*;

    localparam logic [PC_BITS-1:0] c_pc_step = PC_BITS'(4);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;

    logic [PC_BITS-1:0] r_pc;
    logic [PC_BITS-1:0] r_req_pc;
    logic               r_out_valid;
    logic [INSTR_W-1:0] r_out_instr;
    logic [PC_BITS-1:0] r_out_pc;
    logic               r_flush;
    logic               r_trap;
    logic [PC_BITS-1:0] r_trap_pc;

    logic               w_skid_full;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [PC_BITS-1:0] w_skid_pc;

    logic               w_req;
    logic               w_granted;
    logic               w_redir;
    logic               w_misalign;
    logic               w_owed_after_redir;
    logic               w_rsp_accept;
    logic               w_out_ready;
    logic               w_skid_load;
    logic               w_skid_pop;

    assign w_req      = (r_state == ST_REQ) && !w_skid_full;
    assign w_granted  = w_req && imem_gnt_i;
    assign w_redir    = redir_valid_i && (r_state != ST_TRAP);
    assign w_misalign = w_redir && is_misaligned(redir_pc_i[1:0]);

    // An rvalid seen together with the redirect settles the outstanding fetch;
    // a grant in the same cycle creates a new one that must still be dropped.
    assign w_owed_after_redir = w_granted ||
                                (((r_state == ST_WAIT) || (r_state == ST_KILL)) && !imem_rvalid_i);

    assign w_rsp_accept = (r_state == ST_WAIT) && imem_rvalid_i && !w_redir;
    assign w_out_ready  = !r_out_valid || !stall_i;
    assign w_skid_load  = w_rsp_accept && !w_out_ready;
    assign w_skid_pop   = !w_redir && (r_state != ST_TRAP) && w_out_ready && w_skid_full;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_REQ;
            ST_REQ:  if (w_granted)     w_state_nxt = ST_WAIT;
            ST_WAIT: if (imem_rvalid_i) w_state_nxt = ST_REQ;
            ST_KILL: if (imem_rvalid_i) w_state_nxt = ST_REQ;
            ST_TRAP: w_state_nxt = ST_TRAP;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_redir) begin
            if (w_misalign)              w_state_nxt = ST_TRAP;
            else if (w_owed_after_redir) w_state_nxt = ST_KILL;
            else                         w_state_nxt = ST_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else if (w_redir) begin
            r_pc     <= redir_pc_i;
        end else if (w_granted) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + c_pc_step;
        end
    end

    // Output register: skid entry is older than any response, so it drains first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
        end else if (w_redir || (r_state == ST_TRAP)) begin
            r_out_valid <= 1'b0;
        end else if (w_out_ready) begin
            if (w_skid_full) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_skid_instr;
                r_out_pc    <= w_skid_pc;
            end else if (w_rsp_accept) begin
                r_out_valid <= 1'b1;
                r_out_instr <= imem_rdata_i;
                r_out_pc    <= r_req_pc;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush   <= 1'b0;
            r_trap    <= 1'b0;
            r_trap_pc <= '0;
        end else begin
            r_flush <= w_redir;
            if (w_misalign) begin
                r_trap    <= 1'b1;
                r_trap_pc <= redir_pc_i;
            end
        end
    end

    fetch_skid_buf #(
        .PC_BITS (PC_BITS),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_redir),
        .i_load  (w_skid_load),
        .i_pop   (w_skid_pop),
        .i_instr (imem_rdata_i),
        .i_pc    (r_req_pc),
        .o_full  (w_skid_full),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_pc;
    assign instr_valid_o = r_out_valid;
    assign instr_o       = r_out_instr;
    assign instr_pc_o    = r_out_pc;
    assign flush_o       = r_flush;
    assign trap_o        = r_trap;
    assign trap_pc_o     = r_trap_pc;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ============================================================================
//  Module      : tb_pc_fetch_ctrl
//  Description : Directed vector bench for pc_fetch_ctrl plus a wrap instance.
//  Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pc_fetch_ctrl;

    typedef struct packed {
        logic       stall;
        logic       redir;
        logic [7:0] rpc;
        logic       gnt;
        logic       rv;
        logic [7:0] dpc;
        logic       req;
        logic [7:0] addr;
        logic       iv;
        logic [7:0] ipc;
        logic       fl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_nw = 1'b0;

    logic        stall_i = 1'b0;
    logic        redir_valid_i = 1'b0;
    logic [7:0]  redir_pc_i = 8'h00;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        imem_req_o;
    logic [7:0]  imem_addr_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [7:0]  instr_pc_o;
    logic        flush_o;
    logic        trap_o;
    logic [7:0]  trap_pc_o;

    logic        req_w;
    logic [7:0]  addr_w;
    logic        gnt_w;
    logic        rv_w;
    logic [31:0] rdata_w;
    logic        iv_w;
    logic [31:0] instr_w;
    logic [7:0]  ipc_w;
    logic        fl_w;
    logic        tr_w;
    logic [7:0]  tpc_w;

    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        vecs[$];
    logic [7:0]  wq_addr[$];
    logic [7:0]  wq_ipc[$];

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.PC_BITS(8), .RESET_PC(8'h00), .INSTR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redir_valid_i (redir_valid_i),
        .redir_pc_i    (redir_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .flush_o       (flush_o),
        .trap_o        (trap_o),
        .trap_pc_o     (trap_pc_o)
    );

    pc_fetch_ctrl #(.PC_BITS(8), .RESET_PC(8'hF8), .INSTR_W(32)) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_nw),
        .stall_i       (1'b0),
        .redir_valid_i (1'b0),
        .redir_pc_i    (8'h00),
        .imem_req_o    (req_w),
        .imem_addr_o   (addr_w),
        .imem_gnt_i    (gnt_w),
        .imem_rvalid_i (rv_w),
        .imem_rdata_i  (rdata_w),
        .instr_valid_o (iv_w),
        .instr_o       (instr_w),
        .instr_pc_o    (ipc_w),
        .flush_o       (fl_w),
        .trap_o        (tr_w),
        .trap_pc_o     (tpc_w)
    );

    // Zero-wait memory for the wrap instance: grant at once, data next cycle.
    assign gnt_w = req_w;
    always @(posedge clk or negedge rst_nw) begin
        if (!rst_nw) begin
            rv_w    <= 1'b0;
            rdata_w <= 32'h0;
        end else begin
            rv_w    <= req_w;
            rdata_w <= {24'h0, addr_w};
        end
    end

    always @(negedge clk) begin
        if (rst_nw) begin
            if (req_w) wq_addr.push_back(addr_w);
            if (iv_w)  wq_ipc.push_back(ipc_w);
        end
    end

    function automatic logic [31:0] dat(input logic [7:0] pc);
        return {16'hBEEF, 8'h5A, pc};
    endfunction

    function automatic vec_t mk(input int stall, input int redir, input int rpc,
                                input int gnt, input int rv, input int dpc,
                                input int req, input int addr, input int iv,
                                input int ipc, input int fl);
        vec_t v;
        v.stall = 1'(stall);
        v.redir = 1'(redir);
        v.rpc   = 8'(rpc);
        v.gnt   = 1'(gnt);
        v.rv    = 1'(rv);
        v.dpc   = 8'(dpc);
        v.req   = 1'(req);
        v.addr  = 8'(addr);
        v.iv    = 1'(iv);
        v.ipc   = 8'(ipc);
        v.fl    = 1'(fl);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [7:0] addr,
                              input logic iv, input logic [7:0] ipc, input logic fl,
                              input logic tr);
        check({tag, " req"},   32'(imem_req_o),    32'(req));
        check({tag, " addr"},  32'(imem_addr_o),   32'(addr));
        check({tag, " valid"}, 32'(instr_valid_o), 32'(iv));
        check({tag, " flush"}, 32'(flush_o),       32'(fl));
        check({tag, " trap"},  32'(trap_o),        32'(tr));
        if (iv) begin
            check({tag, " ipc"},   32'(instr_pc_o), 32'(ipc));
            check({tag, " instr"}, instr_o,         dat(ipc));
        end
    endtask

    task automatic drive(input logic stall, input logic redir, input logic [7:0] rpc,
                         input logic gnt, input logic rv, input logic [7:0] dpc);
        stall_i       = stall;
        redir_valid_i = redir;
        redir_pc_i    = rpc;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = dat(dpc);
    endtask

    initial begin
        logic [7:0] wrap_exp [3];
        wrap_exp[0] = 8'hF8;
        wrap_exp[1] = 8'hFC;
        wrap_exp[2] = 8'h00;

        // sequential fetch 0x00..0x0C
        vecs.push_back(mk(0,0,'h00,0,0,'h00, 0,'h00,0,'h00,0));
        vecs.push_back(mk(0,0,'h00,1,0,'h00, 1,'h00,0,'h00,0));
        vecs.push_back(mk(0,0,'h00,0,1,'h00, 0,'h04,0,'h00,0));
        vecs.push_back(mk(0,0,'h00,1,0,'h00, 1,'h04,1,'h00,0));
        vecs.push_back(mk(0,0,'h00,0,1,'h04, 0,'h08,0,'h00,0));
        vecs.push_back(mk(0,0,'h00,1,0,'h00, 1,'h08,1,'h04,0));
        vecs.push_back(mk(0,0,'h00,0,1,'h08, 0,'h0C,0,'h00,0));
        vecs.push_back(mk(0,0,'h00,1,0,'h00, 1,'h0C,1,'h08,0));
        vecs.push_back(mk(0,0,'h00,0,1,'h0C, 0,'h10,0,'h00,0));
        vecs.push_back(mk(0,0,'h00,1,0,'h00, 1,'h10,1,'h0C,0));
        // redirect to 0x40 while 0x10 is outstanding
        vecs.push_back(mk(0,1,'h40,0,0,'h00, 0,'h14,0,'h00,0));
        vecs.push_back(mk(0,0,'h00,0,1,'h10, 0,'h40,0,'h00,1));
        vecs.push_back(mk(0,0,'h00,1,0,'h00, 1,'h40,0,'h00,0));
        vecs.push_back(mk(0,0,'h00,0,1,'h40, 0,'h44,0,'h00,0));
        // stall five cycles, second response lands in the skid buffer
        vecs.push_back(mk(1,0,'h00,1,0,'h00, 1,'h44,1,'h40,0));
        vecs.push_back(mk(1,0,'h00,0,1,'h44, 0,'h48,1,'h40,0));
        vecs.push_back(mk(1,0,'h00,1,0,'h00, 0,'h48,1,'h40,0));
        vecs.push_back(mk(1,0,'h00,1,0,'h00, 0,'h48,1,'h40,0));
        vecs.push_back(mk(1,0,'h00,1,0,'h00, 0,'h48,1,'h40,0));
        vecs.push_back(mk(0,0,'h00,0,0,'h00, 0,'h48,1,'h40,0));
        vecs.push_back(mk(0,0,'h00,1,0,'h00, 1,'h48,1,'h44,0));
        vecs.push_back(mk(0,0,'h00,0,1,'h48, 0,'h4C,0,'h00,0));
        vecs.push_back(mk(0,0,'h00,0,0,'h00, 1,'h4C,1,'h48,0));
        // redirect with nothing owed: new request next cycle
        vecs.push_back(mk(0,1,'h80,0,0,'h00, 1,'h4C,0,'h00,0));
        vecs.push_back(mk(0,0,'h00,1,0,'h00, 1,'h80,0,'h00,1));
        vecs.push_back(mk(0,0,'h00,0,1,'h80, 0,'h84,0,'h00,0));
        // redirect with same-cycle gnt, then redirect with same-cycle rvalid
        vecs.push_back(mk(0,1,'h20,1,0,'h00, 1,'h84,1,'h80,0));
        vecs.push_back(mk(0,1,'h30,0,1,'h84, 0,'h20,0,'h00,1));
        vecs.push_back(mk(0,0,'h00,1,0,'h00, 1,'h30,0,'h00,1));
        // redirect in WAIT then again in KILL: still one drop
        vecs.push_back(mk(0,1,'h60,0,0,'h00, 0,'h34,0,'h00,0));
        vecs.push_back(mk(0,1,'h64,0,0,'h00, 0,'h60,0,'h00,1));
        vecs.push_back(mk(0,0,'h00,0,1,'h34, 0,'h64,0,'h00,1));
        vecs.push_back(mk(0,0,'h00,1,0,'h00, 1,'h64,0,'h00,0));
        vecs.push_back(mk(0,0,'h00,0,1,'h64, 0,'h68,0,'h00,0));
        vecs.push_back(mk(0,0,'h00,1,0,'h00, 1,'h68,1,'h64,0));

        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        check("reset wrap addr", 32'(addr_w), 32'h0000_00F8);
        check("reset trap_pc", 32'(trap_pc_o), 32'h0);

        @(negedge clk);
        rst_n  = 1'b1;
        rst_nw = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].gnt, vecs[i].rv, vecs[i].dpc);
            #1;
            check_outs($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].iv,
                       vecs[i].ipc, vecs[i].fl, 1'b0);
            @(negedge clk);
        end

        // async reset while a fetch is outstanding
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        #1;
        check_outs("arst", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h6C);
        #1;
        check_outs("stray idle", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h6C);
        #1;
        check_outs("stray req", 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        #1;
        check_outs("restart req", 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
        #1;
        check_outs("restart wait", 1'b0, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);

        // misaligned redirect with a grant in the same cycle
        drive(1'b0, 1'b1, 8'h42, 1'b1, 1'b0, 8'h00);
        #1;
        check_outs("pre trap", 1'b1, 8'h04, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'(k & 1), 1'b1, 8'h10, 1'b1, 1'b1, 8'h04);
            #1;
            check($sformatf("trap%0d trap", k),   32'(trap_o),        32'h1);
            check($sformatf("trap%0d tpc", k),    32'(trap_pc_o),     32'h42);
            check($sformatf("trap%0d req", k),    32'(imem_req_o),    32'h0);
            check($sformatf("trap%0d valid", k),  32'(instr_valid_o), 32'h0);
            check($sformatf("trap%0d flush", k),  32'(flush_o),       (k == 0) ? 32'h1 : 32'h0);
        end

        // wrap instance: fetch and delivery order across 0xFC -> 0x00
        for (int j = 0; j < 3; j++) begin
            if (wq_addr.size() > j) check($sformatf("wrap addr%0d", j), 32'(wq_addr[j]), 32'(wrap_exp[j]));
            else                    check("wrap addr count", 32'(wq_addr.size()), 32'(j + 1));
            if (wq_ipc.size() > j)  check($sformatf("wrap ipc%0d", j), 32'(wq_ipc[j]), 32'(wrap_exp[j]));
            else                    check("wrap ipc count", 32'(wq_ipc.size()), 32'(j + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Consumer end of the jump-target path: accepts the resolved redirect target and taken strobe from the execute stage, owns the architectural fetch PC, and drives instruction fetch.
- Issues one request at a time to instruction memory using a grant/rvalid handshake.
- Buffers the fetched instruction toward decode through an output register plus a one-entry skid buffer.
- Generates a flush pulse and discards in-flight fetches on redirect; traps on misaligned targets.

Parameters:
- PC_BITS, 8, width of the byte-address PC (bits [PC_BITS-1:0]).
- RESET_PC, 8'h00, PC loaded at reset.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  decode cannot accept; hold the output instruction.
- redir_valid_i  in  1  taken jal/jalr/branch; one-cycle strobe.
- redir_pc_i  in  PC_BITS  redirect target byte address.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  PC_BITS  fetch address (the pc_q value).
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid, at least 1 cycle after gnt.
- imem_rdata_i  in  INSTR_W  response instruction.
- instr_valid_o  out  1  instruction available to decode.
- instr_o  out  INSTR_W  instruction to decode.
- instr_pc_o  out  PC_BITS  PC of instr_o.
- flush_o  out  1  registered one-cycle pulse; kill IF/ID contents.
- trap_o  out  1  misaligned redirect trap, sticky until reset.
- trap_pc_o  out  PC_BITS  offending target.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc_q=RESET_PC, skid empty.
  - All outputs 0, except imem_addr_o, which shows pc_q.
- States:
  - IDLE: unconditional; go to REQ on the next cycle.
  - REQ: drive imem_req_o=1 when the skid buffer is empty. On gnt, latch req_pc_q=pc_q and set pc_q=pc_q+4 (mod 2^PC_BITS, so 0xFC wraps to 0x00), then go to WAIT.
  - WAIT: hold imem_req_o=0. On rvalid, write {rdata, req_pc_q} into the output register if instr_valid_o=0 or stall_i=0; otherwise write it into the skid buffer. Then go to REQ.
  - KILL: one response is owed. Drop the next rvalid without writing, then go to REQ.
  - TRAP: imem_req_o=0 and instr_valid_o=0. All inputs are ignored until reset.
- Output register:
  - While stall_i=1 and instr_valid_o=1, instr_o and instr_pc_o are held.
  - When stall_i=0, the output register loads from the skid buffer if it is full. Otherwise it loads the rvalid data this cycle, or clears valid.
  - The skid buffer never overflows: REQ does not issue while the skid buffer is full.
- Redirect (redir_valid_i=1) has priority over stall, gnt and rvalid in the same cycle:
  - pc_q <= redir_pc_i.
  - instr_valid_o <= 0 and skid cleared.
  - flush_o=1 on the next cycle.
  - If a response is owed (state WAIT, or REQ with gnt this cycle), go to KILL; else go to REQ.
  - Redirect in KILL: update pc_q and stay in KILL; still exactly one response is dropped.
  - An rvalid arriving in the same cycle as a redirect counts as the owed response. It is dropped and the block goes to REQ, not KILL.
- Misalignment: if redir_pc_i[1:0] != 0, go to TRAP with trap_o=1 and trap_pc_o=redir_pc_i; flush_o still pulses. If a response was still owed, it is ignored.
- Latency: gnt to instr_valid_o is rvalid+1 cycle. Redirect to first new imem_req_o is 1 cycle when nothing is outstanding.
- Reset asserted mid-transaction: all state is abandoned. A later stray rvalid seen in IDLE or REQ is ignored.

Decomposition:
- Shared package (cpu_pkg):
  - PC_BITS.
  - RESET_PC.
  - Opcode constants OP_JAL=7'b1101111, OP_JALR=7'b1100111, OP_BRANCH=7'b1100011, shared with the target calculator.
  - FSM state encoding: IDLE, REQ, WAIT, KILL, TRAP.
- Sub-module fetch_skid_buf: one-entry {instr, pc} holding register with full flag, load, pop and clear.

Test Plan:
- Sequential fetch: gnt in the same cycle as req, rvalid 1 cycle later, 4 fetches from 0x00 -> imem_addr_o 0x00,0x04,0x08,0x0C and instr_pc_o in the same order, no gaps beyond the handshake.
- Wrap: RESET_PC=0xF8 -> fetch addresses 0xF8, 0xFC, 0x00.
- Stall plus skid: hold stall_i=1 for 5 cycles with a response arriving -> instr_o unchanged and the skid buffer holds the next instruction, no request issued while the skid buffer is full. Release stall -> the two instructions appear in consecutive cycles in PC order.
- Redirect in WAIT: redir_valid_i with target 0x40 while a fetch of 0x10 is outstanding -> flush_o pulses once, the 0x10 response is dropped, the next request is to 0x40, and the next instr_pc_o is 0x40.
- Misaligned: redir_pc_i=0x42 -> trap_o=1 and trap_pc_o=0x42, no further imem_req_o, state held until rst_n.
- Async reset mid-WAIT: rst_n low for 1 cycle -> outputs 0 immediately, a stale rvalid afterwards is ignored, and fetch restarts at RESET_PC.
